// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by fetch_unit and its instruction buffer.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries. Flush beats push in the
// same cycle; push while full is legal only together with a pop.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  fetch_entry_t  i_data,
    output fetch_entry_t  o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !i_flush && o_full && !i_pop));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word requests to imem, buffers responses
// with their PCs and hands them to decode; redirects flush and restart fetch.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_gnt_in,
    input  logic        imem_rvalid_in,
    input  logic [31:0] imem_rdata_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic        instr_valid_out,
    input  logic        instr_ready_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out
);

    localparam int          CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CAP = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic         r_active;

    logic [CW:0]   w_inflight;
    logic [CW-1:0] w_outstanding_nxt;
    logic [CW-1:0] w_count;
    logic [31:0]   w_redirect_pc;
    logic          w_fire;
    logic          w_rsp;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    fetch_entry_t  w_push_data;
    fetch_entry_t  w_head;

    // Requests granted but not yet answered plus buffered words never exceed the buffer size.
    assign w_inflight        = {1'b0, r_outstanding} + {1'b0, w_count};
    assign imem_req_out      = r_active && !redirect_in && (w_inflight < CAP);
    assign imem_addr_out     = r_fetch_pc;
    assign w_fire            = imem_req_out && imem_gnt_in;

    // A response with nothing outstanding is left over from before a reset.
    assign w_rsp             = imem_rvalid_in && (r_outstanding != '0);
    assign w_drop            = w_rsp && (redirect_in || (r_discard != '0));
    assign w_push            = w_rsp && !w_drop;
    assign w_pop             = instr_valid_out && instr_ready_in;
    assign w_outstanding_nxt = r_outstanding + CW'(w_fire) - CW'(w_rsp);
    assign w_redirect_pc     = word_align(redirect_pc_in);
    assign w_push_data       = '{pc: r_resp_pc, instr: imem_rdata_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= word_align(RESET_PC);
            r_resp_pc     <= word_align(RESET_PC);
            r_outstanding <= '0;
            r_discard     <= '0;
            r_active      <= 1'b0;
        end else begin
            r_active      <= 1'b1;
            r_outstanding <= w_outstanding_nxt;
            if (redirect_in) begin
                // Everything still in flight after this edge belongs to the old path.
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                r_discard  <= w_outstanding_nxt;
            end else begin
                if (w_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
                if (w_rsp && (r_discard != '0)) begin
                    r_discard <= r_discard - CW'(1);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_in),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign instr_valid_out = !w_empty;
    assign instr_out       = w_head.instr;
    assign pc_out          = w_head.pc;

    a_push_room: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !redirect_in && w_full && !w_pop));
    a_inflight_cap: assert property (@(posedge clk) disable iff (!rst_n)
        w_inflight <= CAP);

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decode/control unit.
- Keeps the fetch PC and issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- On a branch/jump redirect from execute, flushes buffered and in-flight instructions and restarts fetch at the target.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- FIFO_DEPTH, 2, entries in the instruction buffer; also the cap on in-flight plus buffered requests. Power of two, at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_out  output  1  fetch request valid.
- imem_addr_out  output  32  fetch address, word aligned.
- imem_gnt_in  input  1  request accepted this cycle (req&gnt).
- imem_rvalid_in  input  1  response valid. Responses arrive in order, at least 1 cycle after grant.
- imem_rdata_in  input  32  instruction word.
- redirect_in  input  1  branch/jump taken; one-cycle pulse.
- redirect_pc_in  input  32  redirect target.
- instr_valid_out  output  1  instr_out/pc_out hold a valid instruction.
- instr_ready_in  input  1  decode accepts the instruction.
- instr_out  output  32  instruction word for the control unit's instr_in.
- pc_out  output  32  address of instr_out.

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - outstanding=0, discard=0, FIFO empty.
  - imem_req_out=0, instr_valid_out=0, instr_out=0, pc_out=0.
  - The first request may assert in the first cycle after reset deassertion.
- Issue:
  - imem_req_out=1 when (outstanding + fifo_count) < FIFO_DEPTH and redirect_in=0.
  - imem_addr_out=fetch_pc. Addr is held stable while req=1 and gnt=0.
  - On req&gnt: fetch_pc += 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0); outstanding += 1.
- Response:
  - On rvalid with discard>0: drop the word; discard -= 1; outstanding -= 1.
  - Otherwise: push {resp_pc, rdata} into the FIFO; resp_pc += 4; outstanding -= 1.
  - Push never overflows because of the issue cap. An overflow attempt is an assertion failure.
- Output:
  - instr_valid_out = FIFO non-empty; instr_out/pc_out = FIFO head.
  - Pop on valid&ready.
  - Push into an empty FIFO is visible at the output the next cycle. Minimum latency from grant to instr_valid_out is 2 cycles.
  - Simultaneous push and pop when full is legal; count is unchanged.
- Redirect (redirect_in=1):
  - fetch_pc and resp_pc <= {redirect_pc_in[31:2],2'b00}.
  - FIFO flushed; instr_valid_out=0 next cycle.
  - discard <= outstanding, adjusted for same-cycle events:
    - +1 if req&gnt this cycle (cannot occur, since req=0 during redirect).
    - -1 if rvalid this cycle; that response is dropped regardless.
  - Any pop in the redirect cycle is still honoured for decode, because decode consumed it before the branch resolved.
  - Back-to-back redirects: the latest target wins; discard accumulates correctly.
- Counters:
  - outstanding and discard have width clog2(FIFO_DEPTH)+1. They saturate never; underflow is an assertion failure.
- Reset mid-transaction:
  - All counters clear. Responses arriving after reset with outstanding=0 are ignored (no push).

Decomposition:
- Shared package (existing opcode/imm package or new core_pkg):
  - RESET_PC default.
  - INSTR_NOP = 32'h0000_0013.
  - fetch_entry_t struct {pc[31:0], instr[31:0]}.
- One sub-module: fetch_fifo.
  - Parameterised synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, full, empty, count.
  - Flush has priority over push in the same cycle.

Test Plan:
- Reset release, gnt=1 always, rvalid 1 cycle after gnt, ready=1 -> requests at 0x0, 0x4, 0x8.
  - pc_out/instr_out pairs in order; first instr_valid_out 2 cycles after first grant.
- ready=0 for 10 cycles -> FIFO fills to 2; imem_req_out drops to 0; no overflow.
  - On ready=1, instructions at 0x0 and 0x4 are delivered in order, with no loss.
- gnt held 0 for 3 cycles -> imem_addr_out stays constant at 0x8 with req=1.
- 2 requests in flight, redirect_in=1, redirect_pc_in=0x0000_0102 -> next request addr 0x100.
  - Both stale responses dropped; first delivered pc_out=0x100.
- Redirect in the same cycle as rvalid, with one more request in flight -> both stale words dropped (discard ends at 0); 0x200 fetch delivered correctly.
- RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst_n asserted mid-stream -> all outputs 0 immediately.
